// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter
// Summary  : Round-robin arbiter that shares one valid/ready stream sink among
//            NUM_REQ requesters. A grant is held for up to MAX_BURST beats.
//            Beats pass through one output register and carry their source
//            index.
// Revision : 1.0 - initial release
// ============================================================================
module stream_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            in_valid,
   output logic [NUM_REQ-1:0]            in_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [$clog2(NUM_REQ)-1:0]    out_src,
   output logic                          busy,
   output logic [15:0]                   beat_count
);

   localparam int               IDX_W     = $clog2(NUM_REQ);
   localparam logic [7:0]       LAST_BEAT = 8'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [1:0]              rst_sync;
   logic                    rst_n;
   logic [IDX_W-1:0]        grant;
   logic [IDX_W-1:0]        last_grant;
   logic [7:0]              burst_cnt;
   logic                    out_free;
   logic                    xfer;
   logic                    release_grant;
   logic                    arb_found;
   logic [IDX_W-1:0]        arb_idx;
   logic [DATA_WIDTH-1:0]   sel_data;

   // Rotating index helper: keeps the candidate inside 0..NUM_REQ-1
   function automatic logic [IDX_W-1:0] wrap_idx(input int v);
      wrap_idx = IDX_W'(v % NUM_REQ);
   endfunction

   // Reset is applied asynchronously but removed only on a clock edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   // A new beat may enter the output register when it is empty or draining
   assign out_free = !out_valid || out_ready;
   assign xfer     = (state == ST_GRANT) && in_valid[grant] && out_free;
   assign sel_data = in_data[grant*DATA_WIDTH +: DATA_WIDTH];
   assign busy     = (state == ST_GRANT);

   // Grant ends after the last beat of a burst or when the owner drops valid
   assign release_grant = (state == ST_GRANT) &&
                          ((xfer && (burst_cnt == LAST_BEAT)) || !in_valid[grant]);

   // Round-robin search starting just after the previous owner
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!arb_found && in_valid[wrap_idx(int'(last_grant) + k)]) begin
            arb_found = 1'b1;
            arb_idx   = wrap_idx(int'(last_grant) + k);
         end
      end
   end

   // Only the granted requester sees ready, and only when the output can take it
   always_comb begin
      in_ready = '0;
      if (state == ST_GRANT) begin
         in_ready[grant] = out_free;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (arb_found) begin
               state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (release_grant) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Grant bookkeeping: owner, previous owner and beats taken in this burst
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant      <= '0;
         last_grant <= LAST_IDX;
         burst_cnt  <= 8'd0;
      end else begin
         if ((state == ST_IDLE) && arb_found) begin
            grant     <= arb_idx;
            burst_cnt <= 8'd0;
         end else if (xfer) begin
            burst_cnt <= burst_cnt + 8'd1;
         end
         if (release_grant) begin
            last_grant <= grant;
         end
      end
   end

   // Output register and accepted-beat counter; a held beat drains on out_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= '0;
         beat_count <= 16'd0;
      end else begin
         if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= sel_data;
            out_src    <= grant;
            beat_count <= beat_count + 16'd1;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_rr_arbiter
// Summary  : Directed bench for stream_rr_arbiter with a beat scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_rr_arbiter;

   logic        clk;
   logic        reset_n;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_src;
   logic        busy;
   logic [15:0] beat_count;

   // Second instance with long bursts, used to reach the counter wrap quickly
   logic [1:0]  w_in_valid;
   logic [1:0]  w_in_ready;
   logic [15:0] w_in_data;
   logic        w_out_valid;
   logic        w_out_ready;
   logic [7:0]  w_out_data;
   logic        w_out_src;
   logic        w_busy;
   logic [15:0] w_beat_count;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]  rq_data [4][16];
   int          rq_len  [4];
   int          rq_ptr  [4];
   logic [9:0]  sb [$];

   logic [3:0]  s_in_ready;
   logic        s_out_valid;
   logic [7:0]  s_out_data;
   logic        s_busy;
   int          st_high, st_low, st_pend;
   logic        st_seen;

   stream_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_src(out_src), .busy(busy), .beat_count(beat_count)
   );

   stream_rr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(255)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in_data(w_in_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_data(w_out_data), .out_src(w_out_src), .busy(w_busy),
      .beat_count(w_beat_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reqs();
      for (int i = 0; i < 4; i++) begin
         if (rq_ptr[i] < rq_len[i]) begin
            in_valid[i]       = 1'b1;
            in_data[i*8 +: 8] = rq_data[i][rq_ptr[i]];
         end else begin
            in_valid[i]       = 1'b0;
            in_data[i*8 +: 8] = 8'h00;
         end
      end
   endtask

   task automatic load(input int r, input logic [7:0] base, input int n);
      for (int k = 0; k < n; k++) rq_data[r][k] = base + 8'(k);
      rq_len[r] = n;
      rq_ptr[r] = 0;
   endtask

   task automatic push_exp(input int r, input logic [7:0] base, input int first, input int n);
      for (int k = first; k < first + n; k++) sb.push_back({2'(r), base + 8'(k)});
   endtask

   task automatic clear_all();
      for (int i = 0; i < 4; i++) begin
         rq_len[i] = 0;
         rq_ptr[i] = 0;
      end
      sb.delete();
      apply_reqs();
   endtask

   task automatic stats_clear();
      st_high = 0; st_low = 0; st_pend = 0; st_seen = 1'b0;
   endtask

   // One clock: sample at the falling edge, advance requesters after the rising edge
   task automatic step();
      logic [3:0] hs;
      logic [9:0] e;
      @(negedge clk);
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      s_out_data  = out_data;
      s_busy      = busy;
      hs          = in_valid & in_ready;
      if (out_valid) begin
         st_high = st_high + 1;
         st_low  = st_low + (st_seen ? st_pend : 0);
         st_pend = 0;
         st_seen = 1'b1;
      end else if (st_seen) begin
         st_pend = st_pend + 1;
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_beat", {22'd0, out_src, out_data}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("beat", {22'd0, out_src, out_data}, {22'd0, e});
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (hs[i]) rq_ptr[i]++;
      apply_reqs();
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((sb.size() != 0 || in_valid != 4'd0 || out_valid || busy) && n < maxc) begin
         step();
         n++;
      end
      check("drain_timeout", 32'(n < maxc), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 reset_n = 1'b0;
      clear_all();
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] wexp [3];
      logic        hit;
      logic        got;
      reset_n     = 1'b0;
      out_ready   = 1'b1;
      in_valid    = 4'd0;
      in_data     = 32'd0;
      w_in_valid  = 2'd0;
      w_in_data   = 16'd0;
      w_out_ready = 1'b1;
      clear_all();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_beat_count", 32'(beat_count), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_src", 32'(out_src), 32'd0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Sole requester 2, six beats: burst of 4, one idle cycle, then 2 more
      begin
         logic [11:0] ov_pat;
         logic [11:0] busy_pat;
         load(2, 8'h10, 6);
         push_exp(2, 8'h10, 0, 6);
         apply_reqs();
         stats_clear();
         for (int k = 0; k < 12; k++) begin
            step();
            ov_pat[k]   = s_out_valid;
            busy_pat[k] = s_busy;
         end
         check("solo_out_valid_pattern", 32'(ov_pat), 32'h1BC);
         check("solo_busy_pattern", 32'(busy_pat), 32'h1DE);
         drain(50);
         check("solo_beat_count", 32'(beat_count), 32'd6);
      end

      // All four requesters continuously valid: order 0,1,2,3,0,1,2,3
      do_reset();
      for (int i = 0; i < 4; i++) load(i, 8'(i * 16), 8);
      for (int half = 0; half < 2; half++)
         for (int i = 0; i < 4; i++) push_exp(i, 8'(i * 16), half * 4, 4);
      apply_reqs();
      stats_clear();
      drain(200);
      check("all_beats_out", 32'(st_high), 32'd32);
      check("all_gap_cycles", 32'(st_low), 32'd7);
      check("all_beat_count", 32'(beat_count), 32'd32);

      // Requester 1 sends two beats and drops; waiting requester 3 goes next
      load(1, 8'hA0, 2);
      load(3, 8'hB0, 2);
      push_exp(1, 8'hA0, 0, 2);
      push_exp(3, 8'hB0, 0, 2);
      apply_reqs();
      drain(60);
      check("drop_beat_count", 32'(beat_count), 32'd36);

      // Requester 0 with downstream stall for two cycles
      load(0, 8'hC0, 4);
      push_exp(0, 8'hC0, 0, 4);
      apply_reqs();
      step();
      step();
      check("stall_pre_ready", 32'(s_in_ready), 32'h1);
      out_ready = 1'b0;
      step();
      check("stall1_in_ready", 32'(s_in_ready), 32'h0);
      check("stall1_out_valid", 32'(s_out_valid), 32'd1);
      check("stall1_out_data", 32'(s_out_data), 32'hC0);
      step();
      check("stall2_in_ready", 32'(s_in_ready), 32'h0);
      check("stall2_out_data", 32'(s_out_data), 32'hC0);
      out_ready = 1'b1;
      drain(60);
      check("stall_beat_count", 32'(beat_count), 32'd40);

      // Asynchronous reset mid-burst, then order restarts at requester 0
      load(1, 8'hD0, 8);
      push_exp(1, 8'hD0, 0, 8);
      apply_reqs();
      step();
      step();
      step();
      #3 reset_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_beat_count", 32'(beat_count), 32'd0);
      clear_all();
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      load(0, 8'hE0, 2);
      load(2, 8'hF0, 2);
      push_exp(0, 8'hE0, 0, 2);
      push_exp(2, 8'hF0, 0, 2);
      apply_reqs();
      step();
      step();
      check("postrst_first_grant", 32'(s_in_ready), 32'h1);
      drain(60);
      check("postrst_beat_count", 32'(beat_count), 32'd4);

      // Beat counter wrap on the long-burst instance
      wexp[0] = 16'hFFFF;
      wexp[1] = 16'h0000;
      wexp[2] = 16'h0001;
      hit = 1'b0;
      w_in_data  = 16'h005A;
      w_in_valid = 2'b01;
      for (int n = 0; n < 70000 && !hit; n++) begin
         @(posedge clk);
         #1;
         if (w_beat_count == 16'hFFFE) hit = 1'b1;
      end
      w_in_valid = 2'b00;
      check("wrap_preload", 32'(w_beat_count), 32'hFFFE);
      repeat (3) @(posedge clk);
      #1;
      check("wrap_hold", 32'(w_beat_count), 32'hFFFE);
      for (int k = 0; k < 3; k++) begin
         w_in_data  = {8'h00, 8'hE0 + 8'(k)};
         w_in_valid = 2'b01;
         got = 1'b0;
         for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (w_in_ready[0]) got = 1'b1;
         end
         @(posedge clk);
         #1;
         w_in_valid = 2'b00;
         check("wrap_handshake", 32'(got), 32'd1);
         check("wrap_count", 32'(w_beat_count), 32'(wexp[k]));
         check("wrap_out_data", 32'(w_out_data), 32'(8'hE0 + 8'(k)));
         repeat (3) @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Round-robin arbiter sharing one 8-bit valid/ready stream sink (the stream_in_* side of the sample datapath) among NUM_REQ requesters.
- Grants one requester at a time and holds the grant for a burst of up to MAX_BURST beats.
- Forwards data through a single output register and tags each beat with its source index.
- Sits between cocotb-driven requester streams and the datapath stream input.

Parameters:
- NUM_REQ, 4, number of requester streams (2..8).
- DATA_WIDTH, 8, payload width per beat.
- MAX_BURST, 4, maximum beats per grant before forced rotation (1..255).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  NUM_REQ  per-requester valid.
- in_ready  output  NUM_REQ  per-requester ready.
- in_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_data  output  DATA_WIDTH  registered output data.
- out_src  output  $clog2(NUM_REQ)  index of the requester that supplied out_data.
- busy  output  1  high while state is GRANT.
- beat_count  output  16  total accepted beats; wraps from 0xFFFF to 0.

Behaviour:
- Reset (async assert, sync release). All of the following are cleared immediately, regardless of state or pending transfers:
  - state=IDLE
  - out_valid=0, out_data=0, out_src=0
  - in_ready=0, busy=0, beat_count=0
  - burst counter=0
  - last_grant=NUM_REQ-1, so requester 0 has first priority
- Handshake: a beat transfers on a rising edge where valid && ready.
  - in_valid must not depend on in_ready.
  - in_ready is combinational from state, grant index, out_valid and out_ready.
- Output register: out_free = !out_valid || out_ready.
- State IDLE:
  - in_ready all 0.
  - If any in_valid: grant = first asserted index searching last_grant+1, last_grant+2, ... modulo NUM_REQ. Register grant, clear the burst counter, go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT (grant index g):
  - in_ready[g] = out_free; all other bits are 0.
  - On a transfer: out_data<=in_data[g], out_src<=g, out_valid<=1, burst counter +1, beat_count +1.
  - If there is no transfer and out_ready=1: out_valid<=0.
  - Release (go to IDLE, last_grant<=g) when:
    - a transfer occurs with burst counter == MAX_BURST-1, or
    - in_valid[g]==0 at a clock edge.
  - Release does not touch out_valid. A pending beat stays until out_ready.
- Latency: in_valid rises in cycle 0 (IDLE) → GRANT in cycle 1 with in_ready high if out_free → out_valid in cycle 2.
  - Re-arbitration costs one idle cycle per grant.
  - Steady-state throughput is MAX_BURST beats per MAX_BURST+1 cycles under continuous demand.
- Fairness: requester g cannot regain the grant while another requester has in_valid high at the IDLE decision cycle.
  - A sole requester is re-granted back to back, with one IDLE cycle between bursts.
- Back-pressure: with out_ready=0 and out_valid=1, in_ready[g]=0. out_data, out_src and out_valid hold stable. The burst counter does not advance.
- Simultaneous events:
  - A transfer on the last burst beat at the same edge that in_valid[g] falls: the beat is accepted and the grant releases once.
  - A new request that arrives during GRANT waits for release.
- beat_count counts input-side transfers and wraps silently.
- Reset asserted mid-burst: any in-flight out beat is dropped. After release the arbitration order restarts at requester 0.

Test Plan:
- Reset, then only requester 2 valid with data 0x10..0x15, out_ready=1, MAX_BURST=4 → out_data 0x10–0x13 with out_src=2, one gap cycle, then 0x14,0x15; beat_count=6.
- All 4 requesters valid continuously, each with a distinct data tag, out_ready=1 → bursts of 4 beats each in order 0,1,2,3,0; out_src follows that order; out_valid has exactly one low cycle between bursts.
- Requester 1 valid for 2 beats then drops, requester 3 waiting → 2 beats from src 1, release, next grant goes to 3; no beat is duplicated or lost.
- Requester 0 bursting with out_ready toggled 1,0,0,1 → out_data is stable while stalled; in_ready[0]=0 during the stall; 4 beats total, in order.
- Preload beat_count to 0xFFFE via traffic, send 3 beats → count reads 0xFFFF, 0x0000, 0x0001.
- reset_n pulsed low mid-burst, asynchronous to clk → out_valid, in_ready and busy drop immediately; after release, requesters 0 and 2 both valid → requester 0 is granted first.
